// File: rtl/apb_pkg.sv
// Shared definitions for the APB round-robin requester controller.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  // Bus phase encoding: IDLE=00, SETUP=01, ACCESS=10
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               any_grant
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] idx;

  // Scan requesters in priority order starting at ptr; first hit wins
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = SUM_W'(ptr) + SUM_W'(k);
      if (idx >= SUM_W'(NUM_REQ)) begin
        idx = idx - SUM_W'(NUM_REQ);
      end
      if (!any_grant && req[IDX_W'(idx)]) begin
        grant[IDX_W'(idx)] = 1'b1;
        any_grant          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB requester-side controller: round-robin arbitration of NUM_REQ local
// requesters onto one APB bus, one transfer in flight.
// Optional feature macro: APB_TIMEOUT_EN -- aborts an ACCESS phase that sees
// no pready within TIMEOUT_CYC cycles and reports it through rsp_err.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("apb_rr_master: NUM_REQ and TIMEOUT_CYC must both be >= 2");
  end

  apb_state_t         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC) > 5) ? $clog2(TIMEOUT_CYC) : 5;
  logic [CNT_W-1:0] tmo_cnt;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .any_grant (any_grant)
  );

  // Binary index of the one-hot grant
  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx = IDX_W'(i);
      end
    end
  end

  // Accept only while idle; masked during reset so nothing handshakes then
  assign req_ready = (state == IDLE && !rst) ? grant : '0;

  assign ptr_next  = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);
  assign sel_write = req_write[gidx];
  assign sel_addr  = req_addr[32'(gidx) * ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[32'(gidx) * DATA_W +: DATA_W];

  // Bus sequencer: IDLE -> SETUP -> ACCESS -> IDLE, all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_grant) begin
            state  <= SETUP;
            psel   <= 1'b1;
            pwrite <= sel_write;
            paddr  <= sel_addr;
            pwdata <= sel_write ? sel_wdata : '0;
            owner  <= gidx;
            ptr    <= ptr_next;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << owner;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= 1'b0;
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << owner;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: directed vector table, reset and
// contention sequences, then randomized traffic against a transaction model.
module tb_apb_rr_master;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [AW-1:0]        paddr;
  logic [DW-1:0]        pwdata;
  logic [DW-1:0]        prdata;
  logic                 pready;

  int n_cmp = 0;
  int n_bad = 0;

  apb_rr_master #(
    .NUM_REQ     (NREQ),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // APB slave model: memory with unwritten locations reading as ~addr
  int   s_waits = 0;
  bit   s_setup_rdy = 1'b0;
  bit   s_rand = 1'b0;
  int   s_cnt = 0;
  logic [31:0] smem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];

  initial begin
    pready = 1'b0;
    prdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !psel) begin
        pready = 1'b0;
      end else if (!penable) begin
        s_cnt  = s_rand ? int'($urandom_range(0, 2)) : s_waits;
        pready = s_setup_rdy;
        prdata = $urandom;
      end else if (s_cnt == 0) begin
        pready = 1'b1;
        if (pwrite) begin
          smem[paddr] = pwdata;
          prdata = $urandom;
        end else begin
          prdata = smem.exists(paddr) ? smem[paddr] : ~paddr;
        end
      end else begin
        pready = 1'b0;
        s_cnt--;
        prdata = $urandom;
      end
    end
  end

  typedef struct {
    int          req;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          sp;
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  // One directed transfer with full cycle-by-cycle bus checking
  task automatic xfer(input vec_t v, input string tag);
    int n;
    int acc;
    logic [31:0] exp_pw;
    s_waits = v.waits;
    s_setup_rdy = v.sp;
    @(negedge clk);
    req_valid[v.req] = 1'b1;
    req_write[v.req] = v.wr;
    req_addr[v.req*AW +: AW] = v.addr;
    req_wdata[v.req*DW +: DW] = v.wdata;
    #1;
    n = 0;
    while (!req_ready[v.req] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_ready"}, 64'(req_ready), 64'd1 << v.req);
    @(negedge clk);
    req_valid[v.req] = 1'b0;
    exp_pw = v.wr ? v.wdata : 32'h0;
    chk({tag, "_setup"}, 64'({psel, penable, pwrite}), 64'({1'b1, 1'b0, v.wr}));
    chk({tag, "_paddr"}, 64'(paddr), 64'(v.addr));
    chk({tag, "_pwdata"}, 64'(pwdata), 64'(exp_pw));
    n = 1;
    acc = 0;
    while (rsp_valid == '0 && n < 100) begin
      @(negedge clk);
      n++;
      if (rsp_valid == '0) begin
        acc++;
        chk({tag, "_access"},
            64'(psel && penable && pwrite == v.wr && paddr == v.addr && pwdata == exp_pw), 64'd1);
      end
    end
    chk({tag, "_latency"}, 64'(n), 64'(v.lat));
    chk({tag, "_access_cycles"}, 64'(acc), 64'(v.lat - 2));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1 << v.req);
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(v.rdata));
    chk({tag, "_err"}, 64'(rsp_err), 64'(v.err));
    chk({tag, "_bus_idle"}, 64'({psel, penable}), 64'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_hold"}, 64'(rsp_rdata), 64'(v.rdata));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel_pen"}, 64'({psel, penable, pwrite}), 64'd0);
    chk({tag, "_paddr"}, 64'(paddr), 64'd0);
    chk({tag, "_pwdata"}, 64'(pwdata), 64'd0);
    chk({tag, "_rsp"}, 64'({rsp_valid, rsp_err}), 64'd0);
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
  endtask

  // Reset asserted for 2 cycles in the middle of an ACCESS phase
  task automatic reset_mid_access();
    int n;
    s_waits = 1000;
    s_setup_rdy = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0 +: AW] = 32'h50;
    req_wdata[0 +: DW] = 32'h77;
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rstmid_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_in_access", 64'({psel, penable}), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rstmid_out");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rstmid_no_rsp", 64'({rsp_valid, psel, penable}), 64'd0);
    end
    s_waits = 0;
  endtask

  // Both requesters valid continuously: grants alternate from index 0
  task automatic contention();
    logic [NREQ-1:0] gq [4];
    int ng;
    int n;
    s_waits = 0;
    s_setup_rdy = 1'b0;
    @(negedge clk);
    req_write = 2'b11;
    req_addr  = {32'h104, 32'h100};
    req_wdata = {32'h2222_0000, 32'h1111_0000};
    req_valid = 2'b11;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (req_ready != '0) begin
        gq[ng] = req_ready;
        if (ng > 0) chk("cont_accept_with_rsp", 64'(rsp_valid != '0), 64'd1);
        ng++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("cont_grants", 64'(ng), 64'd4);
    chk("cont_g0", 64'(gq[0]), 64'd1);
    chk("cont_g1", 64'(gq[1]), 64'd2);
    chk("cont_g2", 64'(gq[2]), 64'd1);
    chk("cont_g3", 64'(gq[3]), 64'd2);
    n = 0;
    while (rsp_valid == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("cont_last_rsp", 64'(rsp_valid), 64'd2);
    @(negedge clk);
  endtask

  // Random traffic checked against a transaction-level RR + memory model
  task automatic run_random(input int ncyc);
    int ptr_m = 0;
    bit busy = 1'b0;
    int age = 0;
    int p_own = 0;
    bit p_wr = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_data = '0;
    logic [31:0] exp_rd;
    logic [NREQ-1:0] acc_last = '0;
    logic [NREQ-1:0] exp_rdy;
    int g;
    int idx;
    for (int c = 0; c < ncyc + 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (acc_last[i] || (req_valid[i] && $urandom_range(0, 15) == 0)) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && c < ncyc && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_write[i] = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW] = 32'($urandom_range(0, 3)) << 2;
          req_wdata[i*DW +: DW] = $urandom;
        end
      end
      #1;
      if (rsp_valid != '0) begin
        chk("rnd_rsp_pending", 64'(busy), 64'd1);
        if (busy) begin
          exp_rd = p_wr ? 32'h0 : (mmem.exists(p_addr) ? mmem[p_addr] : ~p_addr);
          if (p_wr) mmem[p_addr] = p_data;
          chk("rnd_rsp_owner", 64'(rsp_valid), 64'd1 << p_own);
          chk("rnd_rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
          chk("rnd_rsp_err", 64'(rsp_err), 64'd0);
        end
        busy = 1'b0;
      end else if (busy) begin
        age++;
        if (age > 6) begin
          chk("rnd_rsp_late", 64'(age), 64'd6);
          busy = 1'b0;
        end
      end
      exp_rdy = '0;
      g = -1;
      if (!busy) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (ptr_m + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
      acc_last = '0;
      if (g >= 0) begin
        busy   = 1'b1;
        age    = 0;
        p_own  = g;
        p_wr   = req_write[g];
        p_addr = req_addr[g*AW +: AW];
        p_data = req_wdata[g*DW +: DW];
        ptr_m  = (g + 1) % NREQ;
        acc_last[g] = 1'b1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;

    // req, wr, addr, wdata, waits, setup_pready, rdata, err, latency
    vecs.push_back('{0, 1'b1, 32'h10, 32'hA5A5_0001, 0, 1'b0, 32'h0, 1'b0, 3});
    vecs.push_back('{1, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hA5A5_0001, 1'b0, 5});
    vecs.push_back('{1, 1'b1, 32'h20, 32'h1234_5678, 1, 1'b1, 32'h0, 1'b0, 4});
    vecs.push_back('{0, 1'b0, 32'h20, 32'h0, 0, 1'b1, 32'h1234_5678, 1'b0, 3});
    vecs.push_back('{1, 1'b0, 32'h44, 32'h0, 0, 1'b0, 32'hFFFF_FFBB, 1'b0, 3});
`ifdef APB_TIMEOUT_EN
    vecs.push_back('{0, 1'b1, 32'h30, 32'hCAFE_0000, 1000, 1'b0, 32'h0, 1'b1, TO + 2});
    vecs.push_back('{1, 1'b0, 32'h30, 32'h0, 0, 1'b0, 32'hFFFF_FFCF, 1'b0, 3});
`endif
    vecs.push_back('{0, 1'b0, 32'h8, 32'h0, 1, 1'b0, 32'hFFFF_FFF7, 1'b0, 4});

    repeat (3) @(negedge clk);
    chk_all_zero("reset_init");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i], $sformatf("vec%0d", i));
    end

    reset_mid_access();
    contention();

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    smem.delete();
    mmem.delete();
    s_rand = 1'b1;
    run_random(1500);
    s_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
